bcd_serial_adder: RTL and testbench



---
 rtl/bcd_serial_adder_if.sv | 26 ++
 rtl/bcd_serial_adder.sv | 120 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder/subtractor.
// master drives the request side; slave is the adder itself.
interface bcd_serial_adder_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  c_in;
  logic [4*DIGITS-1:0]   s;
  logic                  c_out;
  logic                  busy;
  logic                  done;
  logic                  invalid;

  modport master (
    output start, sub, a, b, c_in,
    input  s, c_out, busy, done, invalid
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output s, c_out, busy, done, invalid
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first, through a
// single 4-bit ripple adder plus decimal correction. Result is shadowed until completion.
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input logic               clk,
  input logic               rst_n,
  bcd_serial_adder_if.slave bus
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DIGITS-1:0][3:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic                   sub_q, sub_d, carry_q, carry_d;
  logic                   c_out_q, c_out_d, inv_q, inv_d;
  logic [IdxW-1:0]        idx_q, idx_d;

  logic [3:0] a_dig, b_dig, b_eff, dig;
  logic [4:0] rc, t;
  logic       cy, nib_bad;

  // Shared digit step: nine's complement of B for subtraction, ripple add, +6 correction.
  always_comb begin
    a_dig = a_q[idx_q];
    b_dig = b_q[idx_q];
    b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
    rc    = '0;
    t     = '0;
    rc[0] = carry_q;
    for (int unsigned i = 0; i < 4; i++) begin
      t[i]    = a_dig[i] ^ b_eff[i] ^ rc[i];
      rc[i+1] = (a_dig[i] & b_eff[i]) | (rc[i] & (a_dig[i] ^ b_eff[i]));
    end
    t[4] = rc[4];
    cy   = (t > 5'd9);
    dig  = cy ? (t[3:0] + 4'd6) : t[3:0];
  end

  always_comb begin
    nib_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) nib_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    inv_d   = inv_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = bus.c_in;
          inv_d   = nib_bad;
          idx_d   = '0;
        end
      end
      StRun: begin
        res_d[idx_q] = dig;
        carry_d      = cy;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          s_d     = inv_q ? '0 : res_d;
          c_out_d = inv_q ? 1'b0 : cy;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      inv_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.s       = s_q;
  assign bus.c_out   = c_out_q;
  assign bus.invalid = inv_q;
  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed and random operations against an
// integer-arithmetic model of decimal add / ten's-complement subtract.
module tb_bcd_serial_adder;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(D)) bus ();
  bcd_serial_adder #(.DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_s = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal model: operands as integers, subtraction as A + (10^D-1-B) + c_in.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, output logic [W-1:0] s, output logic c,
                       output logic inv);
    int unsigned av, bv, r, m;
    logic [3:0] na, nb;
    av = 0; bv = 0; m = 1; inv = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      if (na > 4'd9 || nb > 4'd9) inv = 1'b1;
      av = av * 10 + na;
      bv = bv * 10 + nb;
      m  = m * 10;
    end
    if (sub) bv = m - 1 - bv;
    r = av + bv + cin;
    c = (r >= m);
    r = r % m;
    s = '0;
    for (int i = 0; i < D; i++) begin
      s[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    if (inv) begin
      s = '0;
      c = 1'b0;
    end
  endtask

  task automatic rand_bcd(input bit allow_bad, output logic [W-1:0] v);
    for (int i = 0; i < D; i++) begin
      v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (allow_bad && ($urandom_range(0, 15) == 0)) v[4*i +: 4] = 4'($urandom_range(10, 15));
    end
  endtask

  // Call from the cycle the request should be presented (sampled #1 after an edge).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, input string tag);
    logic [W-1:0] es;
    logic ec, ei;
    int lat, busy_n;
    lat = -1;
    busy_n = 0;
    model(a, b, sub, cin, es, ec, ei);
    bus.a = a; bus.b = b; bus.sub = sub; bus.c_in = cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = ~sub; bus.c_in = ~cin;
    check({tag, ":prev_s"}, 64'(bus.s), 64'(last_s));
    if (bus.busy) busy_n++;
    for (int k = 1; k <= int'(D) + 4; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_n++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(D));
    check({tag, ":busy_cycles"}, 64'(busy_n), 64'(D));
    check({tag, ":s"}, 64'(bus.s), 64'(es));
    check({tag, ":c_out"}, 64'(bus.c_out), 64'(ec));
    check({tag, ":invalid"}, 64'(bus.invalid), 64'(ei));
    last_s = es;
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, r1, r2;
    logic rc1, ri1, rc2, ri2;
    int dn, lat;

    bus.start = 1'b0; bus.sub = 1'b0; bus.c_in = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:s", 64'(bus.s), 64'd0);
    check("rst:c_out", 64'(bus.c_out), 64'd0);
    check("rst:busy", 64'(bus.busy), 64'd0);
    check("rst:done", 64'(bus.done), 64'd0);
    check("rst:invalid", 64'(bus.invalid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, "add1234");
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, "ripple");
    run_op(16'h9999, 16'h0000, 1'b0, 1'b1, "ripple_cin");
    run_op(16'h0500, 16'h0123, 1'b1, 1'b1, "sub_pos");
    run_op(16'h0123, 16'h0500, 1'b1, 1'b1, "sub_neg");
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, "bad_nib");
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "after_bad");

    // start held high; operands change mid-run.
    model(16'h4321, 16'h1111, 1'b0, 1'b0, r1, rc1, ri1);
    model(16'h0808, 16'h0202, 1'b0, 1'b0, r2, rc2, ri2);
    bus.a = 16'h4321; bus.b = 16'h1111; bus.sub = 1'b0; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'h0808; bus.b = 16'h0202;
    dn = 0;
    for (int k = 1; k <= int'(D); k++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    check("hold:done_at_D", 64'(bus.done), 64'd1);
    check("hold:one_done", 64'(dn), 64'd1);
    check("hold:s1", 64'(bus.s), 64'(r1));
    @(posedge clk); #1;
    check("hold:ignored_in_done", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check("hold:accepted_after", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    check("hold:s_shadow", 64'(bus.s), 64'(r1));
    lat = -1;
    for (int k = 1; k <= int'(D) + 4; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("hold:latency2", 64'(lat), 64'(D));
    check("hold:s2", 64'(bus.s), 64'(r2));
    check("hold:c2", 64'(bus.c_out), 64'(rc2));
    last_s = r2;
    @(posedge clk); #1;

    // Reset during RUN with idx=2.
    bus.a = 16'h2468; bus.b = 16'h1357; bus.sub = 1'b0; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst:busy", 64'(bus.busy), 64'd0);
    check("midrst:s", 64'(bus.s), 64'd0);
    check("midrst:c_out", 64'(bus.c_out), 64'd0);
    dn = 0;
    for (int k = 0; k < int'(D) + 2; k++) begin
      if (bus.done) dn++;
      @(posedge clk); #1;
    end
    check("midrst:no_done", 64'(dn), 64'd0);
    last_s = '0;
    run_op(16'h0042, 16'h0058, 1'b0, 1'b0, "post_rst");

    for (int n = 0; n < 24; n++) begin
      rand_bcd(1'b1, ra);
      rand_bcd(1'b1, rb);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
